// File: rtl/edp_op_seq.sv
// Microsequencer that runs one two-operand AD operation on the EDP:
// B -> AR -> BR, A -> AR, settle AD, capture result, optional AD -> AR writeback.
//
// state | meaning
// IDLE  | waiting for req
// LDB   | operand B onto cache data, load AR
// XFER  | BR <= AR
// LDA   | operand A onto cache data, load AR
// OP    | AD function applied, held SETTLE_CYC cycles
// WB    | optional AR <= AD
// DONE  | result valid pulse
module edp_op_seq #(
    parameter int SETTLE_CYC = 1,
    parameter int W          = 36
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic [W-1:0]   opA,
    input  logic [W-1:0]   opB,
    input  logic [5:0]     adFunc,
    input  logic           wbEn,
    output logic           ack,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic [1:0]     resultX,
    output logic [W-1:0]   cacheData,
    output logic [2:0]     cramAR,
    output logic           cramBR,
    output logic [5:0]     cramAD,
    output logic [2:0]     cramADA,
    output logic [1:0]     cramADB,
    output logic [2:0]     arLoad,
    input  logic [W+1:0]   edpAD
);

    localparam logic [2:0] arAR     = 3'd0;
    localparam logic [2:0] arCACHE  = 3'd1;
    localparam logic [2:0] arAD     = 3'd2;
    localparam logic       brRECIRC = 1'b0;
    localparam logic       brAR     = 1'b1;
    localparam logic [5:0] adA      = 6'o25;
    localparam logic [2:0] adaAR    = 3'd0;
    localparam logic [1:0] adbBR    = 2'd2;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, LDB, XFER, LDA, OP, WB, DONE} state_t;

    state_t         state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic [W-1:0]   a_q, b_q;
    logic [5:0]     func_q;
    logic           wb_q;

    logic           ack_nx, busy_nx, done_nx, br_nx;
    logic [W-1:0]   cache_nx;
    logic [2:0]     ar_nx, load_nx;
    logic [5:0]     ad_nx;

    // Outputs are registered from the current state, so each state's
    // control fields appear on the EDP one cycle after the state is entered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        br_nx    = brRECIRC;
        cache_nx = '0;
        ar_nx    = arAR;
        load_nx  = 3'b000;
        ad_nx    = adA;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = LDB;
                    ack_nx   = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            LDB: begin
                busy_nx  = 1'b1;
                cache_nx = b_q;
                ar_nx    = arCACHE;
                load_nx  = 3'b111;
                state_nx = XFER;
            end
            XFER: begin
                busy_nx  = 1'b1;
                br_nx    = brAR;
                state_nx = LDA;
            end
            LDA: begin
                busy_nx  = 1'b1;
                cache_nx = a_q;
                ar_nx    = arCACHE;
                load_nx  = 3'b111;
                cnt_nx   = SETTLE_LAST;
                state_nx = OP;
            end
            OP: begin
                busy_nx = 1'b1;
                ad_nx   = func_q;
                if (cnt == 4'd0) state_nx = WB;
                else             cnt_nx   = cnt - 4'd1;
            end
            WB: begin
                busy_nx = 1'b1;
                ad_nx   = func_q;
                if (wb_q) begin
                    ar_nx   = arAD;
                    load_nx = 3'b111;
                end
                state_nx = DONE;
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= adA;
            wb_q      <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            resultX   <= '0;
            cacheData <= '0;
            cramAR    <= arAR;
            cramBR    <= brRECIRC;
            cramAD    <= adA;
            cramADA   <= adaAR;
            cramADB   <= adbBR;
            arLoad    <= 3'b000;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ack       <= ack_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            cacheData <= cache_nx;
            cramAR    <= ar_nx;
            cramBR    <= br_nx;
            cramAD    <= ad_nx;
            cramADA   <= adaAR;
            cramADB   <= adbBR;
            arLoad    <= load_nx;
            if (state == IDLE && req) begin
                a_q    <= opA;
                b_q    <= opB;
                func_q <= adFunc;
                wb_q   <= wbEn;
            end
            // While in WB the last OP cycle is on the EDP, so AD is settled here.
            if (state == WB) begin
                result  <= edpAD[W-1:0];
                resultX <= edpAD[W+1:W];
            end
        end
    end

endmodule

// File: tb/tb_edp_op_seq.sv
// Bench for edp_op_seq: two instances (SETTLE_CYC 1 and 3) each driving a small
// EDP AR/BR/AD model; a per-instance scoreboard is checked on every done pulse.
module tb_edp_op_seq;

    localparam logic [2:0] arAR        = 3'd0;
    localparam logic [2:0] arCACHE     = 3'd1;
    localparam logic [2:0] arAD        = 3'd2;
    localparam logic       brRECIRC    = 1'b0;
    localparam logic       brAR        = 1'b1;
    localparam logic [5:0] adA         = 6'o25;
    localparam logic [5:0] adB         = 6'o32;
    localparam logic [5:0] adAplusB    = 6'o06;
    localparam logic [5:0] adAx2       = 6'o11;
    localparam logic [5:0] adORCBplus1 = 6'o02;
    localparam logic [2:0] adaAR       = 3'd0;
    localparam logic [1:0] adbBR       = 2'd2;

    typedef struct {
        logic [35:0] a;
        logic [35:0] b;
        logic [5:0]  f;
        logic        wb;
        logic [35:0] res;
        logic [1:0]  x;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, req, wbEn;
    logic [35:0] opA, opB;
    logic [5:0]  adFunc;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // EDP adder with two sign-extension bits: [37:36] = AD[-2:-1].
    function automatic logic [37:0] ad_model(logic [5:0] f, logic [35:0] a, logic [35:0] b);
        logic [37:0] ae, be;
        ae = {{2{a[35]}}, a};
        be = {{2{b[35]}}, b};
        case (f)
            adA:         return ae;
            adB:         return be;
            adAplusB:    return ae + be;
            adAx2:       return ae + ae;
            adORCBplus1: return (ae | ~be) + 38'd1;
            default:     return ae;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int S = (g == 0) ? 1 : 3;
        logic        ack, busy, done, cramBR;
        logic [35:0] result, cacheData;
        logic [1:0]  resultX, cramADB;
        logic [2:0]  cramAR, cramADA, arLoad;
        logic [5:0]  cramAD;
        logic [37:0] edpAD;
        logic [35:0] ar = '0;
        logic [35:0] br = '0;
        vec_t        q[$];
        int          n_ack = 0, n_done = 0, ack_cyc = 0, done_cyc = -100, last_gap = 0;

        edp_op_seq #(.SETTLE_CYC(S), .W(36)) dut (
            .clk(clk), .rst_n(rst_n), .req(req), .opA(opA), .opB(opB),
            .adFunc(adFunc), .wbEn(wbEn), .ack(ack), .busy(busy), .done(done),
            .result(result), .resultX(resultX), .cacheData(cacheData),
            .cramAR(cramAR), .cramBR(cramBR), .cramAD(cramAD), .cramADA(cramADA),
            .cramADB(cramADB), .arLoad(arLoad), .edpAD(edpAD)
        );

        assign edpAD = ad_model(cramAD, ar, br);

        always @(posedge clk) begin
            if (arLoad == 3'b111) begin
                if (cramAR == arCACHE)   ar <= cacheData;
                else if (cramAR == arAD) ar <= edpAD[35:0];
            end
            if (cramBR == brAR) br <= ar;
        end

        always @(negedge clk) begin
            vec_t e;
            if (rst_n) begin
                chk($sformatf("s%0d_arload_uniform", S), (arLoad == 3'b000 || arLoad == 3'b111), 1);
                chk($sformatf("s%0d_load_vs_brxfer", S), (arLoad != 3'b000 && cramBR == brAR), 0);
                if (ack) begin
                    n_ack++;
                    last_gap = cyc - done_cyc;
                    ack_cyc  = cyc;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL s%0d_unexpected_done: got done with no request pending", S);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("s%0d_result", S), result, e.res);
                        chk($sformatf("s%0d_resultX", S), resultX, e.x);
                        chk($sformatf("s%0d_latency", S), cyc - ack_cyc, 5 + S);
                        chk($sformatf("s%0d_busy_at_done", S), busy, 0);
                        chk($sformatf("s%0d_ar_after", S), ar, e.wb ? e.res : e.a);
                        chk($sformatf("s%0d_br_after", S), br, e.b);
                    end
                end
            end
        end

        task automatic chk_idle(string t);
            chk({t, "_ack"}, ack, 0);
            chk({t, "_busy"}, busy, 0);
            chk({t, "_done"}, done, 0);
            chk({t, "_arLoad"}, arLoad, 0);
            chk({t, "_cramAR"}, cramAR, arAR);
            chk({t, "_cramBR"}, cramBR, brRECIRC);
            chk({t, "_cramAD"}, cramAD, adA);
            chk({t, "_cramADA"}, cramADA, adaAR);
            chk({t, "_cramADB"}, cramADB, adbBR);
            chk({t, "_cacheData"}, cacheData, 0);
            chk({t, "_result"}, result, 0);
            chk({t, "_resultX"}, resultX, 0);
        endtask
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(vec_t v);
        u[0].q.push_back(v);
        u[1].q.push_back(v);
    endtask

    task automatic drive(vec_t v);
        opA = v.a; opB = v.b; adFunc = v.f; wbEn = v.wb;
        req = 1'b1;
        push_exp(v);
        step();
        req = 1'b0;
        opA = 36'({$urandom(), $urandom()});
        opB = 36'({$urandom(), $urandom()});
        adFunc = 6'($urandom());
        wbEn = ~v.wb;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((u[0].q.size() != 0 || u[1].q.size() != 0 || u[0].busy || u[1].busy) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: operation still pending after %0d cycles", t);
        end
        step();
    endtask

    vec_t vecs[6];
    vec_t v;
    int   base0, base1, t;

    initial begin
        vecs[0] = '{36'h123456789, 36'h987654321, adAplusB, 1'b1, 36'hAAAAAAAAA, 2'b11};
        vecs[1] = '{36'h123456789, 36'h987654321, adAx2, 1'b0, 36'h2468ACF12, 2'b00};
        vecs[2] = '{36'o123456701234, 36'o007757777, adORCBplus1, 1'b1, 36'o777776721235, 2'b11};
        vecs[3] = '{36'h7FFFFFFFF, 36'h000000001, adAplusB, 1'b0, 36'h800000000, 2'b00};
        vecs[4] = '{36'hFFFFFFFFF, 36'h000000000, adA, 1'b1, 36'hFFFFFFFFF, 2'b11};
        vecs[5] = '{36'h000000000, 36'h555555555, adB, 1'b1, 36'h555555555, 2'b00};

        rst_n = 1'b0; req = 1'b0; opA = '0; opB = '0; adFunc = adA; wbEn = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(3);
        u[0].chk_idle("s1_reset");
        u[1].chk_idle("s3_reset");
        chk("s1_no_ack_idle", u[0].n_ack, 0);
        chk("s3_no_ack_idle", u[1].n_ack, 0);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            wait_idle();
        end

        // req pulsed while busy is ignored
        base0 = u[0].n_ack; base1 = u[1].n_ack;
        drive(vecs[0]);
        step(2);
        req = 1'b1;
        step();
        req = 1'b0;
        wait_idle();
        chk("s1_busy_req_ignored", u[0].n_ack - base0, 1);
        chk("s3_busy_req_ignored", u[1].n_ack - base1, 1);

        // req held high: back-to-back ops, second accepted one cycle after done
        base0 = u[0].n_ack; base1 = u[1].n_ack;
        v = vecs[2];
        opA = v.a; opB = v.b; adFunc = v.f; wbEn = v.wb;
        push_exp(v);
        push_exp(v);
        req = 1'b1;
        t = 0;
        while (u[1].n_ack < base1 + 2 && t < 60) begin
            step();
            t++;
        end
        req = 1'b0;
        if (t >= 60) begin
            checks++;
            errors++;
            $display("FAIL held_req_timeout: second ack not seen within %0d cycles", t);
        end
        wait_idle();
        chk("s1_held_acks", u[0].n_ack - base0, 2);
        chk("s3_held_acks", u[1].n_ack - base1, 2);
        chk("s1_held_gap", u[0].last_gap, 1);
        chk("s3_held_gap", u[1].last_gap, 1);

        // reset during OP: abort, no done, no writeback into AR
        base0 = u[0].n_done; base1 = u[1].n_done;
        drive(vecs[0]);
        step(3);
        rst_n = 1'b0;
        u[0].q.delete();
        u[1].q.delete();
        step();
        rst_n = 1'b1;
        u[0].chk_idle("s1_abort");
        u[1].chk_idle("s3_abort");
        step(12);
        chk("s1_abort_no_done", u[0].n_done - base0, 0);
        chk("s3_abort_no_done", u[1].n_done - base1, 0);
        chk("s1_abort_ar", u[0].ar, vecs[0].a);
        chk("s3_abort_ar", u[1].ar, vecs[0].a);

        drive(vecs[5]);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edp_op_seq.md
Name: edp_op_seq

Overview:
Microsequencer that drives the EDP control fields (CRAM.AR/BR/AD/ADA/ADB selects, CTL AR load enables, MBOX cache-data source) so that a two-operand AD operation runs without a hand-coded state sequence. It accepts one request carrying operand A, operand B and an AD function code. It loads B into BR via AR, loads A into AR, waits for AD to settle, captures the AD result and optionally writes it back to AR. It sits between a test or diagnostic requester (DTE-side or bench) and the EDP, taking the place of hard-wired control in standalone EDP bring-up.

Parameters:
SETTLE_CYC, 1, cycles AD is held stable before capture (legal range 1-15)
W, 36, data word width (fixed to 36 for the EDP)

Ports:
clk  in  1  EDP clock (also drives CLK.EDP)
rst_n  in  1  synchronous active-low reset
req  in  1  start request; sampled only in IDLE
opA  in  W  operand A (presented to AR via cache path)
opB  in  W  operand B (ends up in BR)
adFunc  in  6  CRAM.AD function code (e.g. adA, adB, adAplusB, adORCBplus1, adAx2)
wbEn  in  1  1 = write AD result back into AR at end of op
ack  out  1  one-cycle pulse: request accepted
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse: result valid
result  out  W  AD[0:35] captured at end of settle
resultX  out  2  AD[-2:-1] captured with result
cacheData  out  W  MBOX.CACHE_DATA drive
cramAR  out  3  CRAM.AR select
cramBR  out  1  CRAM.BR select
cramAD  out  6  CRAM.AD
cramADA  out  3  CRAM.ADA
cramADB  out  2  CRAM.ADB
arLoad  out  3  {AR00to08_LOAD, AR09to17_LOAD, ARR_LOAD}, all bits equal
edpAD  in  W+2  EDP.AD[-2:35]

Behaviour:
- Select encodings: ebox.svh enumerators arCACHE/arAD/arAR, brAR/brRECIRC, adaAR, adbBR.
- Reset (rst_n low at posedge): state IDLE; ack=busy=done=0; arLoad=0; cramAR=arAR; cramBR=brRECIRC; cramAD=adA; cramADA=adaAR; cramADB=adbBR; cacheData=0; result=0; resultX=0. Reset mid-operation aborts immediately; no partial writeback is issued after reset.
- All outputs are registered. Each state below lasts one clock unless noted.
- IDLE: outputs at idle values (arLoad=0, cramBR=brRECIRC). On req=1: latch opA, opB, adFunc, wbEn; pulse ack; set busy; go to LDB.
- LDB: cacheData=opB, cramAR=arCACHE, arLoad=3'b111 -> XFER.
- XFER: arLoad=0, cramBR=brAR (BR<=AR) -> LDA.
- LDA: cramBR=brRECIRC, cacheData=opA, cramAR=arCACHE, arLoad=3'b111 -> OP.
- OP: arLoad=0, cramAR=arAR, cramAD=adFunc, cramADA=adaAR, cramADB=adbBR. Hold for SETTLE_CYC cycles using a 4-bit down-counter; on the last cycle capture result=edpAD[0:35], resultX=edpAD[-2:-1] -> WB.
- WB: if wbEn, cramAR=arAD and arLoad=3'b111; otherwise arLoad=0. cramAD is held -> DONE.
- DONE: arLoad=0; done pulse; busy cleared -> IDLE. result/resultX stay stable until the next capture.
- Latency: req accepted at cycle n; done asserted at n+5+SETTLE_CYC. Minimum request spacing equals busy duration +1 (IDLE cycle).
- req while busy: ignored (no ack); the requester must re-assert req after done.
- req held high continuously: a new op is accepted in the IDLE cycle after DONE.
- Operand inputs may change after ack without effect.
- arLoad bits never differ. cramBR=brAR appears only in XFER. arLoad never coincides with cramBR=brAR.

Test Plan:
- Reset then idle 3 cycles -> all outputs at reset values, busy=0, no ack.
- opB=h987654321, opA=h123456789, adFunc=adAplusB, wbEn=1, SETTLE_CYC=1 -> ack at n, done at n+6, result=hAAAAAAAAA, then AR=hAAAAAAAAA and BR=h987654321.
- opA=h123456789, adFunc=adAx2, wbEn=0 -> result=h2468ACF12; AR stays h123456789 (no load in WB).
- opB=o007757777, adFunc=adORCBplus1, SETTLE_CYC=3 -> done at n+8, result equals EDP AD ORCB+1 model; resultX matches edpAD[-2:-1].
- req pulsed again during busy -> no second ack; first op completes normally; held req starts second op exactly one cycle after done.
- rst_n low during OP -> next cycle IDLE, arLoad=0, no done, AR not overwritten by AD.
